// File: rtl/s84_diag.sv
// s84 square-mod fault diagnosis: golden check, then 24-candidate scan.
// Optional S84_DIAG_EARLY_EXIT_EN: leave SCAN on the cycle after the first match.
module s84_diag (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [3:0] b,
  input  logic [7:0] y_obs,
  output logic       busy,
  output logic       done,
  output logic       fault_free,
  output logic       match_found,
  output logic [2:0] f_loc_out,
  output logic [1:0] f_type_out,
  output logic [4:0] match_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } st_t;

  st_t        st;
  st_t        nx;
  logic [7:0] ra;
  logic [3:0] rb;
  logic [7:0] ry;
  logic [4:0] idx;
  logic [7:0] c;
  logic [7:0] cm;
  logic [2:0] loc;
  logic [1:0] typ;
  logic [7:0] golden;
  logic [7:0] cand;
  logic       gok;
  logic       hit;
  logic       last;

  function automatic logic [7:0] smod(
    input logic [7:0] x,
    input logic [7:0] m
  );
    return (m == 8'd0) ? x : (x % m);
  endfunction

  assign c      = {4'd0, rb} * {4'd0, rb};
  assign loc    = idx[2:0];
  assign typ    = idx[4:3] + 2'd1;
  assign golden = smod(c, ra);
  assign cand   = smod(cm, ra);
  assign gok    = (golden == ry);
  assign hit    = (cand == ry);
  assign last   = (idx == 5'd23);
  assign busy   = (st != IDLE);
  assign done   = (st == DONE);

  // inject the current candidate fault into c
  always_comb begin
    cm = c;
    unique case (1'b1)
      (typ == 2'd1): cm[loc] = 1'b0;
      (typ == 2'd2): cm[loc] = 1'b1;
      default:       cm[loc] = ~c[loc];
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= nx;
  end

  // next-state logic
  always_comb begin
    nx = st;
    unique case (st)
      IDLE:  if (start) nx = CHECK;
      CHECK: nx = gok ? DONE : SCAN;
      SCAN: begin
`ifdef S84_DIAG_EARLY_EXIT_EN
        if (hit || last) nx = DONE;
`else
        if (last) nx = DONE;
`endif
      end
      DONE:  nx = IDLE;
      default: nx = IDLE;
    endcase
  end

  // operand latch, scan index and result accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra          <= '0;
      rb          <= '0;
      ry          <= '0;
      idx         <= '0;
      fault_free  <= 1'b0;
      match_found <= 1'b0;
      f_loc_out   <= '0;
      f_type_out  <= '0;
      match_count <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (start) begin
            ra          <= a;
            rb          <= b;
            ry          <= y_obs;
            idx         <= '0;
            fault_free  <= 1'b0;
            match_found <= 1'b0;
            f_loc_out   <= '0;
            f_type_out  <= '0;
            match_count <= '0;
          end
        end
        CHECK: begin
          if (gok) fault_free <= 1'b1;
        end
        SCAN: begin
          idx <= idx + 5'd1;
          if (hit) begin
            match_count <= match_count + 5'd1;
            if (!match_found) begin
              match_found <= 1'b1;
              f_loc_out   <= loc;
              f_type_out  <= typ;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_s84_diag.sv
// Randomized self-checking bench for s84_diag against a
// direct fault-enumeration model.
module tb_s84_diag;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [3:0] b = '0;
  logic [7:0] y_obs = '0;
  logic       busy;
  logic       done;
  logic       fault_free;
  logic       match_found;
  logic [2:0] f_loc_out;
  logic [1:0] f_type_out;
  logic [4:0] match_count;

  int n_chk = 0;
  int n_err = 0;

  s84_diag dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .a(a),
    .b(b),
    .y_obs(y_obs),
    .busy(busy),
    .done(done),
    .fault_free(fault_free),
    .match_found(match_found),
    .f_loc_out(f_loc_out),
    .f_type_out(f_type_out),
    .match_count(match_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int smod(input int x, input int m);
    return (m == 0) ? x : (x % m);
  endfunction

  function automatic int fault(input int c, input int t, input int l);
    int bit_v;
    bit_v = 1 << l;
    if (t == 1) return c & ~bit_v & 255;
    if (t == 2) return c | bit_v;
    return (c ^ bit_v) & 255;
  endfunction

  // enumerate all 24 faults in scan order; derive expected latency
  task automatic model(
    input int ai, input int bi, input int yi,
    output int ff, output int mf, output int el,
    output int et, output int cnt, output int dc
  );
    int c;
    bit stop;
    c = (bi * bi) & 255;
    ff = (smod(c, ai) == yi);
    mf = 0; el = 0; et = 0; cnt = 0; stop = 0;
    dc = ff ? 2 : 26;
    if (!ff) begin
      for (int t = 1; t <= 3; t++)
        for (int l = 0; l < 8; l++)
          if (!stop && smod(fault(c, t, l), ai) == yi) begin
            cnt++;
            if (!mf) begin
              mf = 1; el = l; et = t;
`ifdef S84_DIAG_EARLY_EXIT_EN
              dc = 2 + (t - 1) * 8 + l + 1;
              stop = 1;
`endif
            end
          end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".ff"}, fault_free, 0);
    chk({tag, ".mf"}, match_found, 0);
    chk({tag, ".loc"}, f_loc_out, 0);
    chk({tag, ".typ"}, f_type_out, 0);
    chk({tag, ".cnt"}, match_count, 0);
  endtask

  // called at posedge+1; restart drives start again in cycle 1;
  // rst_at aborts the run with an async reset in that cycle
  task automatic run(
    input string tag, input int ai, input int bi, input int yi,
    input bit restart, input int rst_at
  );
    int ff, mf, el, et, cnt, dc, cyc;
    model(ai, bi, yi, ff, mf, el, et, cnt, dc);
    a = 8'(ai); b = 4'(bi); y_obs = 8'(yi);
    start = 1'b1;
    @(posedge clk); #1;
    start = restart;
    cyc = 1;
    while (!done && cyc < 40) begin
      if (cyc == 1) chk({tag, ".busy"}, busy, 1);
      if (cyc == rst_at) begin
        #2 rst_n = 1'b0;
        #1 chk_zero({tag, ".rst"});
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    chk({tag, ".cyc"}, cyc, dc);
    chk({tag, ".ff"}, fault_free, ff);
    chk({tag, ".mf"}, match_found, mf);
    chk({tag, ".loc"}, f_loc_out, el);
    chk({tag, ".typ"}, f_type_out, et);
    chk({tag, ".cnt"}, match_count, cnt);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".idle"}, busy, 0);
    chk({tag, ".hold"}, match_count, cnt);
    chk({tag, ".holdl"}, f_loc_out, el);
  endtask

  initial begin
    int ai, bi, yi, c, mode;
    #12;
    chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    run("ffree", 200, 5, 25, 0, 0);
    run("scan", 200, 5, 27, 0, 0);
    run("nomatch", 200, 5, 255, 0, 0);
    run("amod0", 0, 3, 9, 1, 0);
    run("abort", 200, 5, 27, 0, 10);
    run("rerun", 200, 5, 27, 0, 0);
    for (int i = 0; i < 25; i++) begin
      ai = $urandom_range(0, 255);
      if (i % 5 == 0) ai = $urandom_range(0, 3);
      bi = $urandom_range(0, 15);
      c = (bi * bi) & 255;
      mode = $urandom_range(0, 2);
      if (mode == 0) yi = $urandom_range(0, 255);
      else if (mode == 1) yi = smod(c, ai);
      else yi = smod(fault(c, $urandom_range(1, 3),
                           $urandom_range(0, 7)), ai);
      run($sformatf("rnd%0d", i), ai, bi, yi,
          1'($urandom_range(0, 1)), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/s84_diag.md
S84_DIAG -- requirements
Module: s84_diag

Interface
REQ-001 Parameters: none; all widths SHALL be fixed.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a diagnosis; sampled only in IDLE.
REQ-005 a  input  8  modulus operand, latched on accepted start.
REQ-006 b  input  4  square operand, latched on accepted start.
REQ-007 y_obs  input  8  observed s84 square-mod output, latched on accepted start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse in DONE.
REQ-010 fault_free  output  1  y_obs equals the fault-free result.
REQ-011 match_found  output  1  at least one fault candidate reproduces y_obs.
REQ-012 f_loc_out  output  3  bit location of the first matching candidate.
REQ-013 f_type_out  output  2  fault type of the first matching candidate: 1=stuck-0, 2=stuck-1, 3=invert.
REQ-014 match_count  output  5  number of matching candidates, range 0..24.

Function
REQ-015 Golden value: c = b*b, 8 bits; result = c % a; when a==0, result SHALL equal c.
REQ-016 Candidate (t,l) SHALL modify bit l of c (stuck-0, stuck-1 or invert per t) before the modulo; all 8 bits, including bit 7, are eligible.
REQ-017 States: IDLE, CHECK, SCAN, DONE.
REQ-018 IDLE->CHECK on an edge with start=1; on that edge the block SHALL latch a/b/y_obs and clear all result outputs.
REQ-019 CHECK lasts 1 cycle; golden==y_obs -> fault_free=1, go to DONE (SCAN skipped); otherwise go to SCAN.
REQ-020 SCAN evaluates one candidate per cycle, index = (t-1)*8 + l, l fastest, t 1..3, 24 cycles total, then DONE.
REQ-021 On each match, match_count SHALL increment; f_loc_out/f_type_out SHALL capture only the first match; match_found SHALL set.
REQ-022 DONE lasts 1 cycle with done=1, then IDLE.
REQ-023 Latency from the start edge: done SHALL be high in cycle 2 (fault-free) or cycle 26 (full scan).
REQ-024 Result outputs SHALL hold after DONE until the next accepted start.
REQ-025 start while busy SHALL be ignored; start high in DONE SHALL be ignored.
REQ-026 No match -> match_found=0, match_count=0, f_loc_out=0, f_type_out=0.

Reset
REQ-027 rst_n low SHALL immediately force IDLE with busy, done, fault_free, match_found, f_loc_out, f_type_out and match_count all 0, including mid-scan.
REQ-028 After release, the first start SHALL behave identically to power-up.

Configuration
REQ-029 Macro S84_DIAG_EARLY_EXIT_EN defined -> SCAN SHALL go to DONE on the cycle after the first match, and match_count SHALL be at most 1.
REQ-030 Macro S84_DIAG_EARLY_EXIT_EN undefined -> the full 24-candidate scan SHALL always run.

Verification
REQ-031 a=200, b=5, y_obs=25, pulse start -> done in cycle 2, fault_free=1, match_found=0, match_count=0.
REQ-032 a=200, b=5, y_obs=27, macro undefined -> done in cycle 26, match_found=1, f_loc_out=1, f_type_out=2, match_count=2.
REQ-033 Same stimulus as REQ-032 with the macro defined -> done in cycle 12, f_loc_out=1, f_type_out=2, match_count=1.
REQ-034 a=200, b=5, y_obs=255 -> done in cycle 26, fault_free=0, match_found=0, all result fields 0.
REQ-035 a=0, b=3, y_obs=9 -> fault_free=1; then a second start in cycle 1 is ignored.
REQ-036 rst_n pulsed low in cycle 10 of the REQ-032 run -> busy=0 and all outputs 0 asynchronously; a rerun after release reproduces the REQ-032 results.
